// File: rtl/ex_mul_sequencer.sv
// Iterative unsigned WIDTHxWIDTH shift-add multiplier controller for MUL/UMULH in EX.
// Stalls the pipeline while iterating, then presents the selected product half for one cycle.
module ex_mul_sequencer #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [WIDTH:0]   sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // One shift-add step: conditionally add the multiplicand, then shift {hi,lo} right.
    always_comb begin
        sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    mcand_d = op_a;
                    lo_d    = op_b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    mode_d  = mode;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = sum[WIDTH:1];
                    lo_d  = {sum[0], lo_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall drops in DONE so the EX/MEM register advances and captures the result.
    always_comb begin
        stall        = ((state_q == S_IDLE) && start && !flush) || (state_q == S_BUSY);
        busy         = (state_q == S_BUSY);
        result_valid = (state_q == S_DONE);
        result       = result_valid ? (mode_q ? hi_q : lo_q) : '0;
    end

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// Self-checking bench for ex_mul_sequencer against a plain 128-bit multiply reference.
module tb_ex_mul_sequencer;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned CNT_W = 7;

    logic             clk;
    logic             rst;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int errors = 0;

    ex_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .op_a         (op_a),
        .op_b         (op_b),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b, input logic m);
        logic [127:0] p;
        p = 128'(a) * 128'(b);
        return m ? p[127:64] : p[63:0];
    endfunction

    task automatic idle_outputs(input string tag);
        chk({tag, "_stall"}, 64'(stall), 64'd0);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_rv"},    64'(result_valid), 64'd0);
        chk({tag, "_res"},   result, 64'd0);
    endtask

    // Issue one multiply from IDLE and follow it to the DONE cycle, scrambling
    // operands/mode/start while busy to show they are captured at start.
    task automatic do_mul(input logic [63:0] a, input logic [63:0] b, input logic m, input string tag);
        int n;
        logic [63:0] exp;
        exp = ref_mul(a, b, m);
        @(negedge clk);
        op_a = a; op_b = b; mode = m; start = 1'b1; flush = 1'b0;
        #1;
        chk({tag, "_start_stall"}, 64'(stall), 64'd1);
        chk({tag, "_start_rv"}, 64'(result_valid), 64'd0);
        n = 0;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            start = 1'($urandom);
            mode  = 1'($urandom);
            op_a  = {$urandom, $urandom};
            op_b  = {$urandom, $urandom};
            #1;
        end
        chk({tag, "_stall_cycles"}, 64'(n), 64'd65);
        chk({tag, "_rv"}, 64'(result_valid), 64'd1);
        chk({tag, "_result"}, result, exp);
        start = 1'b0;
    endtask

    task automatic watch_no_rv(input int cycles, input string tag);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (result_valid) pulses++;
        end
        chk({tag, "_no_rv"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        #1;
        idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        #1;
        idle_outputs("post_reset");

        // Directed products, issued back-to-back with no gap after DONE.
        do_mul(64'd3, 64'd5, 1'b0, "m3x5");
        do_mul('1, '1, 1'b0, "ones_lo");
        do_mul('1, '1, 1'b1, "ones_hi");
        do_mul('1, 64'd2, 1'b1, "ff_x2_hi");
        do_mul(64'd0, {$urandom, $urandom}, 1'b1, "zero");
        @(negedge clk);
        start = 1'b0;
        #1;
        idle_outputs("after_b2b");

        // start with flush in IDLE is dropped.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op_a = 64'd6; op_b = 64'd7;
        #1;
        chk("idle_flush_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        chk("idle_flush_busy", 64'(busy), 64'd0);

        // Flush in BUSY cycle 20, then restart.
        @(negedge clk);
        op_a = 64'd7; op_b = 64'd9; mode = 1'b0; start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 20) flush = 1'b1;
        end
        #1;
        chk("flush_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        idle_outputs("flush_after");
        watch_no_rv(70, "flush");
        do_mul(64'd4, 64'd4, 1'b0, "m4x4");

        // Reset in BUSY cycle 40.
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op_a = 64'd11; op_b = 64'd13; mode = 1'b0; start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 40) rst = 1'b1;
        end
        #1;
        chk("rst_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        idle_outputs("rst_mid");
        watch_no_rv(70, "rst_mid");

        // Randomized products.
        for (int k = 0; k < 10; k++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (k % 3 == 0) rb = 64'($urandom);
            do_mul(ra, rb, 1'($urandom), $sformatf("rand%0d", k));
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        idle_outputs("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mul_sequencer.md
Name: ex_mul_sequencer

Overview:
- Multi-cycle controller for an iterative unsigned 64x64 shift-add multiplier used by MUL and UMULH in the EX stage.
- Sits beside the EX-stage ALU and takes already-forwarded operands, i.e. the post-forwarding-mux A/B values.
- Holds a pipeline stall while the iteration runs, then presents the result for one cycle so the EX/MEM register captures it instead of the ALU result.

Parameters:
- WIDTH, 64, operand width in bits.
- CNT_W, 7, iteration counter width; must hold the value WIDTH.

Ports:
- clk, input, 1: clock; all state changes on rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: EX instruction is a multiply; sampled only in IDLE.
- mode, input, 1: 0 = MUL (low WIDTH bits of product), 1 = UMULH (high WIDTH bits).
- op_a, input, WIDTH: multiplicand, forwarded ALU_A.
- op_b, input, WIDTH: multiplier, forwarded ALU_B.
- flush, input, 1: squash the in-flight multiply, e.g. a taken branch in ID.
- stall, output, 1: freeze PC, IF/ID and ID/EX registers.
- busy, output, 1: state is BUSY.
- result_valid, output, 1: one-cycle pulse; result is valid.
- result, output, WIDTH: selected product half.

Behaviour:
- State machine: IDLE, BUSY, DONE. State is registered; all datapath registers are registered.
- Reset (rst=1 at an edge):
  - state goes to IDLE; hi, lo, mcand and cnt clear to 0; mode_q clears to 0.
  - Outputs after reset: stall=0, busy=0, result_valid=0, result=0.
  - Reset wins over every other input in every state, including mid-BUSY.
- IDLE:
  - start=1 and flush=0: load mcand<=op_a, lo<=op_b, hi<=0, cnt<=0, mode_q<=mode; go to BUSY.
  - start=1 and flush=1: ignore start; stay in IDLE.
  - Otherwise stay in IDLE.
- BUSY, one iteration per cycle:
  - sum = {1'b0,hi} + (lo[0] ? {1'b0,mcand} : 0), WIDTH+1 bits.
  - Then {hi,lo} <= {sum,lo} >> 1, i.e. hi<=sum[WIDTH:1], lo<={sum[0],lo[WIDTH-1:1]}.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge, go to DONE.
  - flush=1 in BUSY: go to IDLE at that edge; registers keep their values, no result_valid.
  - start is ignored in BUSY.
- DONE:
  - Lasts exactly one cycle, then goes to IDLE unconditionally.
  - start and flush are ignored in DONE.
- Combinational outputs:
  - stall = (state==IDLE && start && !flush) || state==BUSY. stall is 0 in DONE, so the pipeline advances and latches the result.
  - busy = (state==BUSY).
  - result_valid = (state==DONE).
  - result = result_valid ? (mode_q ? hi : lo) : 0.
- Latency:
  - start sampled in IDLE at edge E0.
  - BUSY for WIDTH cycles, edges E1..E64.
  - result_valid=1 for the cycle after E64.
  - stall is high for WIDTH+1 cycles: the start cycle plus WIDTH BUSY cycles.
- Back-to-back multiplies: the next multiply reaches EX in the cycle after DONE, while the block is in IDLE, and is accepted normally. No bubble cycle is needed beyond DONE.
- Arithmetic: unsigned only; the full 2*WIDTH product is exact and there is no overflow indication. Flags are not produced; setFlags multiplies are not supported.
- Operands are captured at start; later changes on op_a, op_b or mode have no effect until the next start.

Test Plan:
- rst=1 for 2 cycles, then idle -> stall=0, busy=0, result_valid=0, result=0.
- op_a=3, op_b=5, mode=0, start=1 for one cycle:
  - stall=1 for 65 consecutive cycles starting in the start cycle.
  - In the 66th cycle: result_valid=1 for exactly one cycle, result=15, stall=0.
- op_a=op_b=0xFFFF_FFFF_FFFF_FFFF:
  - mode=0 -> result=0x0000_0000_0000_0001.
  - Rerun with mode=1 -> result=0xFFFF_FFFF_FFFF_FFFE.
- op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=2, mode=1 -> result=1. Mid-BUSY, op_a changes to 0 and start toggles; the result is unaffected.
- Flush and restart:
  - Start 7x9, assert flush in BUSY cycle 20 -> IDLE next cycle, stall=0, no result_valid.
  - Then start 4x4 -> result=16 after 65 stall cycles.
- Reset mid-operation: assert rst in BUSY cycle 40 -> IDLE, all outputs 0 the following cycle, no result_valid ever pulses for that operation.
